booth_radix4_mul: RTL

Parametrised radix-4 (modified Booth) sequential multiplier. It is the successor to the fixed 8-bit radix-2 Booth unit:
- The operand width is a parameter.
- Signed or unsigned operation is selected per operation.
- Two product bits are retired per iteration.
- The 2W-bit product is streamed out on the shared W-bit `obus` as low word then high word.

It sits on the same `ibus`/`obus` byte-bus style datapath. Operands are loaded serially on `ibus`, and completion is reported on `stop`.

---
 rtl/booth_radix4_mul.sv | 134 +++++++++++++
 1 files changed

// File: rtl/booth_radix4_mul.sv
// Radix-4 (modified Booth) sequential multiplier, W-bit operands loaded serially on ibus,
// 2W-bit product streamed on obus as low word then high word.
//
// state  | meaning
// IDLE   | waiting for bgn; captures multiplicand and mode
// LOAD_Q | captures multiplier, clears accumulator and counter
// ADD    | adds the Booth digit multiple of M into A
// SHIFT  | arithmetic right shift of {A,Q,q-1} by 2, counts iterations
// OUT_LO | obus carries product low word
// OUT_HI | obus carries product high word
// DONE   | stop high until bgn is released
module booth_radix4_mul #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         bgn,
  input  logic         sgn,
  input  logic [W-1:0] ibus,
  output logic [W-1:0] obus,
  output logic         busy,
  output logic         stop
);

  localparam int XW = W + 2;
  localparam int AW = W + 4;
  localparam int SW = AW + XW + 1;
  localparam int CW = $clog2(W / 2 + 2);

  typedef enum logic [2:0] {IDLE, LOAD_Q, ADD, SHIFT, OUT_LO, OUT_HI, DONE} state_t;

  state_t          state;
  logic            mode;
  logic [XW-1:0]   m;
  logic [XW-1:0]   q;
  logic [AW-1:0]   a;
  logic            q1;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  p;

  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   m2;
  logic [AW-1:0]   a_add;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   n_iter;
  logic [SW-1:0]   sh;
  logic [2*W-1:0]  p_nxt;

  assign m_ext   = {{2{m[XW-1]}}, m};
  assign m2      = {m_ext[AW-2:0], 1'b0};
  assign n_iter  = mode ? CW'(W / 2) : CW'(W / 2 + 1);
  assign cnt_nxt = cnt + CW'(1);
  assign sh      = $signed({a, q, q1}) >>> 2;
  // Signed mode shifts out only W multiplier bits, so the product sits two bits higher.
  assign p_nxt   = mode ? sh[2*W+2:3] : sh[2*W:1];

  always_comb begin
    a_add = a;
    case ({q[1:0], q1})
      3'b001, 3'b010: a_add = a + m_ext;
      3'b011:         a_add = a + m2;
      3'b100:         a_add = a - m2;
      3'b101, 3'b110: a_add = a - m_ext;
      default:        a_add = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      mode  <= 1'b0;
      m     <= '0;
      q     <= '0;
      a     <= '0;
      q1    <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      obus  <= '0;
      busy  <= 1'b0;
      stop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bgn) begin
            m     <= sgn ? {{2{ibus[W-1]}}, ibus} : {2'b00, ibus};
            mode  <= sgn;
            busy  <= 1'b1;
            state <= LOAD_Q;
          end
        end
        LOAD_Q: begin
          q     <= mode ? {{2{ibus[W-1]}}, ibus} : {2'b00, ibus};
          a     <= '0;
          q1    <= 1'b0;
          cnt   <= '0;
          state <= ADD;
        end
        ADD: begin
          a     <= a_add;
          state <= SHIFT;
        end
        SHIFT: begin
          {a, q, q1} <= sh;
          cnt        <= cnt_nxt;
          if (cnt_nxt == n_iter) begin
            p     <= p_nxt;
            obus  <= p_nxt[W-1:0];
            state <= OUT_LO;
          end else begin
            state <= ADD;
          end
        end
        OUT_LO: begin
          obus  <= p[2*W-1:W];
          state <= OUT_HI;
        end
        OUT_HI: begin
          obus  <= '0;
          busy  <= 1'b0;
          stop  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!bgn) begin
            stop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
